// File: rtl/dbus_lsu_if.sv
// rtl/dbus_lsu_if.sv - data bus request/response types and interface with master/slave modports

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface dbus_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_lsu.sv
// rtl/dbus_lsu.sv - load/store unit: one registered dbus request per accepted op, one writeback pulse

module dbus_lsu
    import dbus_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_rd,
    dbus_if.master      dbus,
    output logic        resp_valid,
    output logic        resp_rf_we,
    output logic [4:0]  resp_rd,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [31:0] WL = WAIT_LIMIT;

    logic [1:0]  state_q, state_d;
    dbus_req_t   dreq_q, dreq_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [63:0] data_q, data_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;

    logic [2:0]  off;
    logic        misaligned;
    logic        illegal;
    logic [7:0]  st_strobe;
    logic [63:0] raw;
    logic [63:0] load_ext;

    // Decode of the op presented in IDLE
    always_comb begin
        off = req_addr[2:0];
        case (req_funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        st_strobe = 8'h00;
        if (req_we) begin
            case (req_funct3[1:0])
                2'd0:    st_strobe = 8'h01 << off;
                2'd1:    st_strobe = 8'h03 << off;
                2'd2:    st_strobe = 8'h0F << off;
                default: st_strobe = 8'hFF;
            endcase
        end
    end

    // Load alignment uses the held request address, valid on the data_ok cycle
    always_comb begin
        raw = dbus.dresp.data >> {dreq_q.addr[2:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{56{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_ext = {{32{raw[31]}}, raw[31:0]};
            3'b100:  load_ext = {56'd0, raw[7:0]};
            3'b101:  load_ext = {48'd0, raw[15:0]};
            3'b110:  load_ext = {32'd0, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dreq_d  = dreq_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        rf_we_d = rf_we_q;
        rd_d    = rd_q;
        we_d    = we_q;
        f3_d    = f3_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_d          = req_rd;
                    we_d          = req_we;
                    f3_d          = req_funct3;
                    cnt_d         = 32'd0;
                    dreq_d.addr   = req_addr;
                    dreq_d.size   = {1'b0, req_funct3[1:0]};
                    dreq_d.strobe = st_strobe;
                    dreq_d.data   = req_wdata << {off, 3'b000};
                    if (illegal || misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        data_d  = 64'd0;
                        rf_we_d = 1'b0;
                    end else begin
                        state_d      = BUSY;
                        dreq_d.valid = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (dbus.dresp.data_ok) begin
                    state_d      = RESP;
                    dreq_d.valid = 1'b0;
                    err_d        = 1'b0;
                    data_d       = we_q ? 64'd0 : load_ext;
                    rf_we_d      = ~we_q & (rd_q != 5'd0);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (WL != 32'd0 && cnt_d == WL) begin
                        state_d      = RESP;
                        dreq_d.valid = 1'b0;
                        err_d        = 1'b1;
                        data_d       = 64'd0;
                        rf_we_d      = 1'b0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                rf_we_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            dreq_q  <= '0;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
            data_q  <= 64'd0;
            rf_we_q <= 1'b0;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            dreq_q  <= dreq_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rf_we_q <= rf_we_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
        end
    end

    assign dbus.dreq  = dreq_q;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rf_we = rf_we_q;
    assign resp_rd    = rd_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dbus_lsu.sv
// tb/tb_dbus_lsu.sv - randomized and directed bench for dbus_lsu against a byte-level reference model

module tb_dbus_lsu;
    import dbus_pkg::*;

    localparam int WL = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_rf_we, resp_err;
    logic [4:0]  resp_rd;
    logic [63:0] resp_data;

    always #5 clk = ~clk;

    dbus_if bus();

    dbus_lsu #(.WAIT_LIMIT(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .dbus       (bus),
        .resp_valid (resp_valid),
        .resp_rf_we (resp_rf_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    int errors = 0;
    int checks = 0;

    logic        exp_en = 1'b0;
    logic        exp_ready, exp_dv, exp_rv, exp_err, exp_rfwe;
    logic [63:0] exp_addr, exp_sdata, exp_rdata;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strb;
    logic [4:0]  exp_rd;

    int          dv_total = 0;
    logic [7:0]  cap_strb;
    logic [2:0]  cap_size;
    logic [63:0] cap_sdata, cap_rdata;
    logic        cap_err, cap_rfwe;
    logic [4:0]  cap_rd;
    int          rv_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [63:0] addr);
        int  sz;
        logic ill;
        sz  = 1 << f3[1:0];
        ill = we ? f3[2] : (f3 == 3'b111);
        return ill || ((int'(addr[2:0]) % sz) != 0);
    endfunction

    function automatic logic [7:0] m_strobe(input logic we, input logic [2:0] f3, input int off);
        logic [15:0] m;
        if (!we) return 8'h00;
        m = ((16'd1 << (1 << f3[1:0])) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_sdata(input logic [63:0] wdata, input int off);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= off) r[8*i +: 8] = wdata[8*(i-off) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] d);
        logic [63:0] r;
        int sz;
        sz = 1 << f3[1:0];
        r  = 64'd0;
        for (int i = 0; i < sz; i++)
            if (off + i < 8) r[8*i +: 8] = d[8*(off+i) +: 8];
        if (!f3[2] && sz < 8 && r[8*sz-1])
            for (int i = sz; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (exp_en) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
            chk("dreq_valid", {63'd0, bus.dreq.valid}, {63'd0, exp_dv});
            if (exp_dv) begin
                chk("dreq_addr", bus.dreq.addr, exp_addr);
                chk("dreq_size", {61'd0, bus.dreq.size}, {61'd0, exp_size});
                chk("dreq_strobe", {56'd0, bus.dreq.strobe}, {56'd0, exp_strb});
                if (exp_strb != 8'h00) chk("dreq_data", bus.dreq.data, exp_sdata);
            end
            chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_rv});
            chk("resp_rf_we", {63'd0, resp_rf_we}, {63'd0, exp_rfwe});
            if (exp_rv) begin
                chk("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
                chk("resp_rd", {59'd0, resp_rd}, {59'd0, exp_rd});
                chk("resp_data", resp_data, exp_rdata);
            end
        end
        if (bus.dreq.valid) begin
            dv_total++;
            cap_strb  = bus.dreq.strobe;
            cap_size  = bus.dreq.size;
            cap_sdata = bus.dreq.data;
        end
        if (resp_valid) begin
            rv_total++;
            cap_rdata = resp_data;
            cap_err   = resp_err;
            cap_rfwe  = resp_rf_we;
            cap_rd    = resp_rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b1;
        exp_dv    = 1'b0;
        exp_rv    = 1'b0;
        exp_rfwe  = 1'b0;
    endtask

    task automatic stray();
        bus.dresp.data_ok = 1'($urandom_range(0, 1));
        bus.dresp.data    = rand64();
    endtask

    // delay = BUSY cycles without data_ok before the data_ok cycle
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd,
                         input logic [63:0] rdata, input int delay);
        int   off;
        int   k;
        logic done;
        off = int'(addr[2:0]);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        set_idle_exp();
        stray();
        step();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = rand64();
        req_wdata  = rand64();
        req_rd     = 5'($urandom_range(0, 31));
        exp_ready  = 1'b0;
        exp_rd     = rd;
        if (m_err(we, f3, addr)) begin
            exp_dv    = 1'b0;
            exp_rv    = 1'b1;
            exp_err   = 1'b1;
            exp_rfwe  = 1'b0;
            exp_rdata = 64'd0;
            stray();
            step();
        end else begin
            exp_addr  = addr;
            exp_size  = {1'b0, f3[1:0]};
            exp_strb  = m_strobe(we, f3, off);
            exp_sdata = m_sdata(wdata, off);
            k    = 0;
            done = 1'b0;
            while (!done) begin
                exp_dv   = 1'b1;
                exp_rv   = 1'b0;
                exp_rfwe = 1'b0;
                bus.dresp.data_ok = (k == delay);
                bus.dresp.data    = (k == delay) ? rdata : rand64();
                step();
                if (k == delay) begin
                    exp_err   = 1'b0;
                    exp_rdata = we ? 64'd0 : m_load(f3, off, rdata);
                    exp_rfwe  = !we && (rd != 5'd0);
                    done      = 1'b1;
                end else if (k + 1 == WL) begin
                    exp_err   = 1'b1;
                    exp_rdata = 64'd0;
                    exp_rfwe  = 1'b0;
                    done      = 1'b1;
                end
                k++;
            end
            exp_dv = 1'b0;
            exp_rv = 1'b1;
            stray();
            step();
        end
        req_valid = 1'b0;
        set_idle_exp();
        stray();
    endtask

    initial begin
        int dv0;
        int rv0;
        logic [2:0]  f3;
        logic [63:0] a;

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
        bus.dresp.data_ok = 1'b0;
        bus.dresp.data    = 64'd0;
        set_idle_exp();
        step();
        step();
        exp_en = 1'b1;
        @(negedge clk);
        chk("rst_dreq_addr", bus.dreq.addr, 64'd0);
        chk("rst_dreq_data", bus.dreq.data, 64'd0);
        chk("rst_dreq_strobe", {56'd0, bus.dreq.strobe}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_rd", {59'd0, resp_rd}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        do_op(1'b1, 3'b010, 64'h1004, 64'hDEADBEEF, 5'd3, 64'd0, 0);
        chk("sw_size", {61'd0, cap_size}, 64'h2);
        chk("sw_strobe", {56'd0, cap_strb}, 64'hF0);
        chk("sw_data", cap_sdata, 64'hDEADBEEF_00000000);
        chk("sw_rf_we", {63'd0, cap_rfwe}, 64'd0);
        chk("sw_err", {63'd0, cap_err}, 64'd0);

        do_op(1'b0, 3'b000, 64'h2007, 64'd0, 5'd5, 64'h80AA_0000_0000_0000, 1);
        chk("lb_data", cap_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd", {59'd0, cap_rd}, 64'd5);
        chk("lb_rf_we", {63'd0, cap_rfwe}, 64'd1);
        do_op(1'b0, 3'b100, 64'h2007, 64'd0, 5'd5, 64'h80AA_0000_0000_0000, 0);
        chk("lbu_data", cap_rdata, 64'h0000_0000_0000_0080);

        dv0 = dv_total;
        do_op(1'b0, 3'b001, 64'h0003, 64'd0, 5'd9, 64'd0, 0);
        chk("lh_mis_no_bus", 64'(dv_total - dv0), 64'd0);
        chk("lh_mis_err", {63'd0, cap_err}, 64'd1);

        dv0 = dv_total;
        do_op(1'b0, 3'b011, 64'h3000, 64'd0, 5'd7, 64'h0123_4567_89AB_CDEF, 4);
        chk("ld_data", cap_rdata, 64'h0123_4567_89AB_CDEF);
        chk("ld_bus_cycles", 64'(dv_total - dv0), 64'd5);

        dv0 = dv_total;
        do_op(1'b0, 3'b010, 64'h4000, 64'd0, 5'd8, 64'd0, 100);
        chk("timeout_bus_cycles", 64'(dv_total - dv0), 64'(WL));
        chk("timeout_err", {63'd0, cap_err}, 64'd1);

        // reset while BUSY, then a late data_ok must be ignored
        rv0 = rv_total;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011;
        req_addr = 64'h3000; req_rd = 5'd7;
        set_idle_exp();
        bus.dresp.data_ok = 1'b0;
        step();
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_dv = 1'b1;
        exp_addr = 64'h3000; exp_size = 3'b011; exp_strb = 8'h00;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_idle_exp();
        bus.dresp.data_ok = 1'b1;
        step();
        bus.dresp.data_ok = 1'b0;
        step();
        step();
        chk("rst_mid_no_resp", 64'(rv_total - rv0), 64'd0);

        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = rand64();
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
            do_op(1'($urandom_range(0, 1)), f3, a, rand64(), 5'($urandom_range(0, 31)),
                  rand64(), $urandom_range(0, WL + 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
